// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_gen : debounced rate select driving a half-period tick/LED toggler  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tick_gen #(
  parameter int CLK_HZ   = 48_000_000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [2:0] rate_sel,
  output logic       tick,
  output logic       led,
  output logic       rate_ack,
  output logic [2:0] active_rate
);

  localparam int CW = $clog2(CLK_HZ / 2) + 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] C_STAB_SAT  = SW'(DEBOUNCE);
  localparam logic [SW-1:0] C_STAB_LOAD = SW'(DEBOUNCE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    debounced_q, debounced_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          tick_q, tick_d;
  logic          led_q, led_d;
  logic          rate_ack_q, rate_ack_d;
  logic [2:0]    active_rate_q, active_rate_d;

  logic [CW-1:0] w_last;

  // Half-period for a rate, floored at one cycle so fast rates tick every clock.
  function automatic logic [CW-1:0] half_period(input logic [2:0] r);
    int p;
    p = CLK_HZ >>> (int'(r) + 1);
    if (p < 1) p = 1;
    return CW'(p);
  endfunction

  assign w_last = half_period(active_rate_q) - CW'(1);

  always_comb begin
    sync1_d     = rate_sel;
    sync2_d     = sync1_q;
    stab_d      = stab_q;
    debounced_d = debounced_q;
    // sync1 != sync2 means sync2 takes a new value on this edge.
    if (sync1_q != sync2_q) begin
      stab_d = '0;
    end else begin
      if (stab_q != C_STAB_SAT) stab_d = stab_q + SW'(1);
      if (stab_q >= C_STAB_LOAD) debounced_d = sync2_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    tick_d        = 1'b0;
    led_d         = led_q;
    rate_ack_d    = 1'b0;
    active_rate_d = active_rate_q;
    case (state_q)
      IDLE: begin
        counter_d     = '0;
        active_rate_d = debounced_q;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d   = IDLE;
          counter_d = '0;
        end else if (counter_q == w_last) begin
          counter_d = '0;
          tick_d    = 1'b1;
          led_d     = ~led_q;
          // Rate changes only land on an interval boundary.
          if (debounced_q != active_rate_q) begin
            active_rate_d = debounced_q;
            rate_ack_d    = 1'b1;
          end
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      debounced_q   <= '0;
      stab_q        <= '0;
      counter_q     <= '0;
      tick_q        <= 1'b0;
      led_q         <= 1'b0;
      rate_ack_q    <= 1'b0;
      active_rate_q <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      debounced_q   <= debounced_d;
      stab_q        <= stab_d;
      counter_q     <= counter_d;
      tick_q        <= tick_d;
      led_q         <= led_d;
      rate_ack_q    <= rate_ack_d;
      active_rate_q <= active_rate_d;
    end
  end

  assign tick        = tick_q;
  assign led         = led_q;
  assign rate_ack    = rate_ack_q;
  assign active_rate = active_rate_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tick_gen : directed self-checking bench for tick_gen (256 Hz, DB=4)   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tick_gen;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] rate_sel;
  logic       tick;
  logic       led;
  logic       rate_ack;
  logic [2:0] active_rate;

  int total;
  int bad;
  int n;
  logic exp_led;

  tick_gen #(.CLK_HZ(256), .DEBOUNCE(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .rate_sel   (rate_sel),
    .tick       (tick),
    .led        (led),
    .rate_ack   (rate_ack),
    .active_rate(active_rate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges from now until tick is seen high; -1 if never within maxc.
  task automatic run_until_tick(input int maxc, output int cnt);
    cnt = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    exp_led  = 1'b0;
    reset_n  = 1'b0;
    en       = 1'b0;
    rate_sel = 3'd0;

    // Reset state
    step(2);
    chk("rst_tick", tick, 0);
    chk("rst_led", led, 0);
    chk("rst_ack", rate_ack, 0);
    chk("rst_rate", active_rate, 0);

    // Basic ticking at rate 0 (P=128)
    reset_n = 1'b1;
    step(2);
    chk("idle_tick", tick, 0);
    en = 1'b1;
    run_until_tick(300, n);
    chk("first_tick_dist", n, 129);
    exp_led = ~exp_led;
    chk("first_tick_led", led, exp_led);
    chk("first_tick_ack", rate_ack, 0);
    step(1);
    chk("tick_one_cycle", tick, 0);
    run_until_tick(300, n);
    chk("second_tick_dist", n, 127);
    exp_led = ~exp_led;
    chk("second_tick_led", led, exp_led);

    // Rate change 0 -> 2 at cycle 40 of the interval
    step(40);
    rate_sel = 3'd2;
    step(5);
    chk("deb_not_yet", dut.debounced_q, 0);
    step(1);
    chk("deb_loaded", dut.debounced_q, 2);
    chk("pending_rate_held", active_rate, 0);
    run_until_tick(300, n);
    chk("adopt_tick_dist", n, 82);
    chk("adopt_ack", rate_ack, 1);
    chk("adopt_rate", active_rate, 2);
    exp_led = ~exp_led;
    chk("adopt_led", led, exp_led);
    step(1);
    chk("ack_one_cycle", rate_ack, 0);
    run_until_tick(300, n);
    chk("rate2_dist", n, 31);
    chk("rate2_no_ack", rate_ack, 0);
    exp_led = ~exp_led;
    chk("rate2_led", led, exp_led);

    // Back to rate 0, then a short glitch to 5
    rate_sel = 3'd0;
    run_until_tick(300, n);
    chk("back0_dist", n, 32);
    chk("back0_ack", rate_ack, 1);
    chk("back0_rate", active_rate, 0);
    exp_led = ~exp_led;
    run_until_tick(300, n);
    chk("rate0_dist", n, 128);
    chk("rate0_no_ack", rate_ack, 0);
    exp_led = ~exp_led;
    step(10);
    rate_sel = 3'd5;
    step(3);
    rate_sel = 3'd0;
    run_until_tick(300, n);
    chk("glitch_dist", n, 115);
    chk("glitch_no_ack", rate_ack, 0);
    chk("glitch_rate", active_rate, 0);
    chk("glitch_deb", dut.debounced_q, 0);
    exp_led = ~exp_led;
    chk("glitch_led", led, exp_led);

    // en dropped at cycle 100, re-raised 10 cycles later
    step(99);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("en_low_tick", tick, 0);
      chk("en_low_led", led, exp_led);
    end
    en = 1'b1;
    run_until_tick(300, n);
    chk("reenable_dist", n, 129);
    exp_led = ~exp_led;
    chk("reenable_led", led, exp_led);

    // en falls on the terminal-count edge: en wins
    step(127);
    en = 1'b0;
    step(1);
    chk("en_wins_tick", tick, 0);
    chk("en_wins_led", led, exp_led);

    // Rate 7 gives P=1: tick every cycle
    rate_sel = 3'd7;
    step(8);
    chk("idle_adopt_rate7", active_rate, 7);
    chk("idle_adopt_no_ack", rate_ack, 0);
    en = 1'b1;
    step(1);
    chk("p1_enable_edge", tick, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      exp_led = ~exp_led;
      chk("p1_tick", tick, 1);
      chk("p1_led", led, exp_led);
      chk("p1_no_ack", rate_ack, 0);
    end

    // Async reset mid-interval with a pending rate change
    en = 1'b0;
    rate_sel = 3'd0;
    step(8);
    chk("idle_rate0", active_rate, 0);
    en = 1'b1;
    step(20);
    rate_sel = 3'd3;
    step(8);
    chk("pend_deb", dut.debounced_q, 3);
    chk("pend_rate", active_rate, 0);
    chk("pre_rst_led", led, exp_led);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_led", led, 0);
    chk("async_rst_ack", rate_ack, 0);
    chk("async_rst_rate", active_rate, 0);
    chk("async_rst_deb", dut.debounced_q, 0);
    step(2);
    en = 1'b0;
    reset_n = 1'b1;
    step(1);
    chk("post_rst_rate", active_rate, 0);
    step(8);
    chk("post_rst_idle_rate", active_rate, 3);
    chk("post_rst_tick", tick, 0);
    chk("post_rst_ack", rate_ack, 0);
    chk("post_rst_led", led, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
